// File: rtl/usb_pd_pkg.sv
// Shared types and 50 MHz timing defaults for the USB PD clock/reset supervisor.
package usb_pd_pkg;

  typedef enum logic [2:0] {
    S_PLL_RST   = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_HOLD      = 3'd3,
    S_RUN       = 3'd4
  } pd_state_e;

  localparam int DEF_RST_PULSE    = 16;
  localparam int DEF_LOCK_TIMEOUT = 50000;  // 1 ms at 50 MHz
  localparam int DEF_LOCK_STABLE  = 1024;
  localparam int DEF_RELEASE_DLY  = 256;
  localparam int DEF_CNT_W        = 16;

  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/usb_pd_sync2.sv
// Generic 2-flop synchronizer; also used for the CC-line inputs.
module usb_pd_sync2 #(
  parameter int           W       = 1,
  parameter logic [W-1:0] RST_VAL = '0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] d_i,
  output logic [W-1:0] q_o
);

  logic [W-1:0] meta_q;
  logic [W-1:0] sync_q;

  // NOTE: non-blocking assignments keep the two stages as distinct flops;
  // blocking here would collapse the chain into a single register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/usb_pd_pll_supervisor.sv
// PLL reset sequencing, lock qualification and PD system-reset release,
// with automatic recovery from lock loss and lock timeout.
module usb_pd_pll_supervisor
  import usb_pd_pkg::*;
#(
  parameter int RST_PULSE    = DEF_RST_PULSE,
  parameter int LOCK_TIMEOUT = DEF_LOCK_TIMEOUT,
  parameter int LOCK_STABLE  = DEF_LOCK_STABLE,
  parameter int RELEASE_DLY  = DEF_RELEASE_DLY,
  parameter int CNT_W        = DEF_CNT_W
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       pll_lock,
  output logic       pll_reset,
  output logic       sys_rst_n,
  output logic       ready,
  output logic [7:0] lock_loss_cnt,
  output logic [7:0] timeout_cnt,
  output logic [2:0] state
);

  localparam logic [CNT_W-1:0] LD_RST     = CNT_W'(RST_PULSE - 1);
  localparam logic [CNT_W-1:0] LD_TIMEOUT = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LD_STABLE  = CNT_W'(LOCK_STABLE - 1);
  localparam logic [CNT_W-1:0] LD_RELEASE = CNT_W'(RELEASE_DLY - 1);

  pd_state_e        state_q, state_d;
  logic [CNT_W-1:0] timer_q, timer_d;
  logic [7:0]       loss_cnt_q, loss_cnt_d;
  logic [7:0]       to_cnt_q, to_cnt_d;
  logic             pll_reset_q, sys_rst_n_q, ready_q;
  logic             lock_s;
  logic             timer_zero;

  usb_pd_sync2 #(
    .W      (1),
    .RST_VAL(1'b0)
  ) u_lock_sync (
    .clk  (clk),
    .rst_n(rst_n),
    .d_i  (pll_lock),
    .q_o  (lock_s)
  );

  assign timer_zero = (timer_q == '0);

  // NOTE: every signal written here gets a default first, so no path through
  // the case can leave one unassigned and infer a latch.
  always_comb begin
    state_d    = state_q;
    timer_d    = timer_q - CNT_W'(1);
    loss_cnt_d = loss_cnt_q;
    to_cnt_d   = to_cnt_q;

    // The timer is reloaded on every state entry, so each branch that
    // changes state also picks the new state's dwell.
    case (state_q)
      S_PLL_RST: begin
        if (timer_zero) begin
          state_d = S_WAIT_LOCK;
          timer_d = LD_TIMEOUT;
        end
      end
      S_WAIT_LOCK: begin
        if (lock_s) begin
          state_d = S_STABLE;
          timer_d = LD_STABLE;
        end else if (timer_zero) begin
          to_cnt_d = sat_inc8(to_cnt_q);
          state_d  = S_PLL_RST;
          timer_d  = LD_RST;
        end
      end
      S_STABLE: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          timer_d = LD_TIMEOUT;
        end else if (timer_zero) begin
          state_d = S_HOLD;
          timer_d = LD_RELEASE;
        end
      end
      S_HOLD: begin
        if (!lock_s) begin
          state_d = S_WAIT_LOCK;
          timer_d = LD_TIMEOUT;
        end else if (timer_zero) begin
          state_d = S_RUN;
          timer_d = '0;
        end
      end
      S_RUN: begin
        timer_d = '0;
        if (!lock_s) begin
          loss_cnt_d = sat_inc8(loss_cnt_q);
          state_d    = S_WAIT_LOCK;
          timer_d    = LD_TIMEOUT;
        end
      end
      default: begin
        state_d = S_PLL_RST;
        timer_d = LD_RST;
      end
    endcase
  end

  // Outputs are registered from the next state so they switch on the same
  // edge as the state register and never glitch.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_PLL_RST;
      timer_q     <= LD_RST;
      loss_cnt_q  <= '0;
      to_cnt_q    <= '0;
      pll_reset_q <= 1'b1;
      sys_rst_n_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      loss_cnt_q  <= loss_cnt_d;
      to_cnt_q    <= to_cnt_d;
      pll_reset_q <= (state_d == S_PLL_RST);
      sys_rst_n_q <= (state_d == S_RUN);
      ready_q     <= (state_d == S_RUN);
    end
  end

  assign pll_reset     = pll_reset_q;
  assign sys_rst_n     = sys_rst_n_q;
  assign ready         = ready_q;
  assign lock_loss_cnt = loss_cnt_q;
  assign timeout_cnt   = to_cnt_q;
  assign state         = state_q;

endmodule

// File: tb/tb_usb_pd_pll_supervisor.sv
// Scenario bench for usb_pd_pll_supervisor with a dwell-time reference model.
module tb_usb_pd_pll_supervisor;

  localparam int P_RST = 4;
  localparam int P_TO  = 20;
  localparam int P_STB = 8;
  localparam int P_REL = 4;

  localparam int M_PLL_RST = 0;
  localparam int M_WAIT    = 1;
  localparam int M_STABLE  = 2;
  localparam int M_HOLD    = 3;
  localparam int M_RUN     = 4;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pll_lock = 1'b0;
  logic       pll_reset, sys_rst_n, ready;
  logic [7:0] lock_loss_cnt, timeout_cnt;
  logic [2:0] state;

  int total = 0;
  int bad   = 0;

  // Reference model: phase plus cycles spent in it, lock seen two edges late.
  int m_state, m_dwell, m_loss, m_to;
  bit m_s1, m_s2;

  initial forever #5 clk = ~clk;

  usb_pd_pll_supervisor #(
    .RST_PULSE   (P_RST),
    .LOCK_TIMEOUT(P_TO),
    .LOCK_STABLE (P_STB),
    .RELEASE_DLY (P_REL),
    .CNT_W       (16)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .pll_lock     (pll_lock),
    .pll_reset    (pll_reset),
    .sys_rst_n    (sys_rst_n),
    .ready        (ready),
    .lock_loss_cnt(lock_loss_cnt),
    .timeout_cnt  (timeout_cnt),
    .state        (state)
  );

  task automatic model_reset();
    m_state = M_PLL_RST;
    m_dwell = 0;
    m_loss  = 0;
    m_to    = 0;
    m_s1    = 1'b0;
    m_s2    = 1'b0;
  endtask

  task automatic model_step(input bit lk);
    bit ls;
    int nxt;
    ls  = m_s2;
    nxt = m_state;
    case (m_state)
      M_PLL_RST: if (m_dwell == P_RST - 1) nxt = M_WAIT;
      M_WAIT: begin
        if (ls) nxt = M_STABLE;
        else if (m_dwell == P_TO - 1) begin
          nxt = M_PLL_RST;
          if (m_to < 255) m_to++;
        end
      end
      M_STABLE: if (!ls) nxt = M_WAIT; else if (m_dwell == P_STB - 1) nxt = M_HOLD;
      M_HOLD:   if (!ls) nxt = M_WAIT; else if (m_dwell == P_REL - 1) nxt = M_RUN;
      M_RUN: begin
        if (!ls) begin
          nxt = M_WAIT;
          if (m_loss < 255) m_loss++;
        end
      end
      default: nxt = M_PLL_RST;
    endcase
    m_dwell = (nxt == m_state) ? m_dwell + 1 : 0;
    m_state = nxt;
    m_s2    = m_s1;
    m_s1    = lk;
  endtask

  // Advance one clock; leaves time at posedge+1 for sampling and driving.
  task automatic tick();
    bit lk;
    lk = pll_lock;
    @(posedge clk);
    model_step(lk);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #1;
    total += 6;
    if (pll_reset !== 1'b1) begin bad++; $display("FAIL reset_pll_reset: got %b want 1", pll_reset); end
    if (sys_rst_n !== 1'b0) begin bad++; $display("FAIL reset_sys_rst_n: got %b want 0", sys_rst_n); end
    if (ready !== 1'b0) begin bad++; $display("FAIL reset_ready: got %b want 0", ready); end
    if (lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL reset_loss_cnt: got %0d want 0", lock_loss_cnt); end
    if (timeout_cnt !== 8'd0) begin bad++; $display("FAIL reset_timeout_cnt: got %0d want 0", timeout_cnt); end
    if (state !== 3'd0) begin bad++; $display("FAIL reset_state: got %0d want 0", state); end
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_bringup();
    int n;
    pll_lock = 1'b0;
    do_reset();
    for (int c = 0; c < 10; c++) begin
      total++;
      if (pll_reset !== (c < P_RST)) begin
        bad++; $display("FAIL bringup_pll_reset c=%0d: got %b want %b", c, pll_reset, (c < P_RST));
      end
      tick();
    end
    pll_lock = 1'b1;
    n = 0;
    while (sys_rst_n !== 1'b1 && n < 100) begin
      tick();
      n++;
      total++;
      if (state !== 3'(m_state)) begin bad++; $display("FAIL bringup_state: got %0d want %0d", state, m_state); end
    end
    total += 4;
    if (n != 2 + P_STB + P_REL + 1) begin bad++; $display("FAIL bringup_latency: got %0d want %0d", n, 2 + P_STB + P_REL + 1); end
    if (ready !== 1'b1) begin bad++; $display("FAIL bringup_ready: got %b want 1", ready); end
    if (lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL bringup_loss_cnt: got %0d want 0", lock_loss_cnt); end
    if (timeout_cnt !== 8'd0) begin bad++; $display("FAIL bringup_timeout_cnt: got %0d want 0", timeout_cnt); end
  endtask

  task automatic test_bounce();
    int n, stb;
    bit saw_wait;
    pll_lock = 1'b0;
    do_reset();
    pll_lock = 1'b1;
    n = 0;
    while (!(m_state == M_STABLE && m_dwell == 2) && n < 100) begin tick(); n++; end
    // Two-cycle sync delay puts the lock_s drop at STABLE timer==3.
    pll_lock = 1'b0;
    tick();
    pll_lock = 1'b1;
    saw_wait = 1'b0;
    for (int k = 0; k < 6 && !saw_wait; k++) begin
      tick();
      if (state === 3'd1) saw_wait = 1'b1;
    end
    total++;
    if (!saw_wait) begin bad++; $display("FAIL bounce_to_wait: got state %0d want 1", state); end
    stb = 0;
    n = 0;
    while (state !== 3'd3 && n < 60) begin
      tick();
      n++;
      if (state === 3'd2) stb++;
    end
    total++;
    if (stb != P_STB) begin bad++; $display("FAIL bounce_requal_len: got %0d want %0d", stb, P_STB); end
    n = 0;
    while (state !== 3'd4 && n < 60) begin tick(); n++; end
    total += 2;
    if (state !== 3'd4) begin bad++; $display("FAIL bounce_reach_run: got %0d want 4", state); end
    if (lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL bounce_loss_cnt: got %0d want 0", lock_loss_cnt); end
  endtask

  task automatic test_loss_in_run();
    int n;
    bit saw_pr;
    pll_lock = 1'b0;
    n = 0;
    while (sys_rst_n === 1'b1 && n < 20) begin tick(); n++; end
    total += 3;
    if (n != 3) begin bad++; $display("FAIL loss_latency: got %0d want 3", n); end
    if (lock_loss_cnt !== 8'd1) begin bad++; $display("FAIL loss_cnt: got %0d want 1", lock_loss_cnt); end
    if (lock_loss_cnt !== 8'(m_loss)) begin bad++; $display("FAIL loss_cnt_model: got %0d want %0d", lock_loss_cnt, m_loss); end
    pll_lock = 1'b1;
    saw_pr = 1'b0;
    n = 0;
    while (sys_rst_n !== 1'b1 && n < 100) begin
      tick();
      n++;
      if (pll_reset === 1'b1) saw_pr = 1'b1;
    end
    total += 2;
    if (saw_pr) begin bad++; $display("FAIL relock_pll_reset: got 1 want 0"); end
    if (ready !== 1'b1) begin bad++; $display("FAIL relock_ready: got %b want 1", ready); end
  endtask

  task automatic test_async_reset();
    #2;
    rst_n = 1'b0;
    #1;
    total += 6;
    if (pll_reset !== 1'b1) begin bad++; $display("FAIL arst_pll_reset: got %b want 1", pll_reset); end
    if (sys_rst_n !== 1'b0) begin bad++; $display("FAIL arst_sys_rst_n: got %b want 0", sys_rst_n); end
    if (ready !== 1'b0) begin bad++; $display("FAIL arst_ready: got %b want 0", ready); end
    if (lock_loss_cnt !== 8'd0) begin bad++; $display("FAIL arst_loss_cnt: got %0d want 0", lock_loss_cnt); end
    if (timeout_cnt !== 8'd0) begin bad++; $display("FAIL arst_timeout_cnt: got %0d want 0", timeout_cnt); end
    if (state !== 3'd0) begin bad++; $display("FAIL arst_state: got %0d want 0", state); end
    #2;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_timeout();
    int last_rise, rises;
    bit prev_pr, sys_seen;
    pll_lock = 1'b0;
    do_reset();
    last_rise = 0;
    rises = 0;
    prev_pr = 1'b1;
    sys_seen = 1'b0;
    for (int c = 1; c <= 3 * (P_RST + P_TO); c++) begin
      tick();
      total += 2;
      if (state !== 3'(m_state)) begin bad++; $display("FAIL to_state c=%0d: got %0d want %0d", c, state, m_state); end
      if (timeout_cnt !== 8'(m_to)) begin bad++; $display("FAIL to_cnt c=%0d: got %0d want %0d", c, timeout_cnt, m_to); end
      if (sys_rst_n !== 1'b0) sys_seen = 1'b1;
      if (pll_reset === 1'b1 && !prev_pr) begin
        rises++;
        total++;
        if (c - last_rise != P_RST + P_TO) begin
          bad++; $display("FAIL to_period: got %0d want %0d", c - last_rise, P_RST + P_TO);
        end
        last_rise = c;
      end
      prev_pr = pll_reset;
    end
    total += 3;
    if (rises != 3) begin bad++; $display("FAIL to_rises: got %0d want 3", rises); end
    if (timeout_cnt !== 8'd3) begin bad++; $display("FAIL to_cnt_final: got %0d want 3", timeout_cnt); end
    if (sys_seen) begin bad++; $display("FAIL to_sys_rst_n: got 1 want 0"); end
  endtask

  task automatic test_saturation();
    for (int c = 0; c < 257 * (P_RST + P_TO); c++) begin
      tick();
      total++;
      if (timeout_cnt !== 8'(m_to)) begin bad++; $display("FAIL sat_cnt: got %0d want %0d", timeout_cnt, m_to); end
    end
    total++;
    if (timeout_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt_260: got %0d want 255", timeout_cnt); end
    repeat (2 * (P_RST + P_TO)) tick();
    total++;
    if (timeout_cnt !== 8'd255) begin bad++; $display("FAIL sat_cnt_hold: got %0d want 255", timeout_cnt); end
  endtask

  task automatic test_random();
    int i, seg, mode;
    pll_lock = 1'b0;
    do_reset();
    i = 0;
    while (i < 3000) begin
      mode = $urandom_range(0, 9);
      if (mode < 5) begin pll_lock = 1'b1; seg = $urandom_range(10, 300); end
      else if (mode < 8) begin pll_lock = 1'b0; seg = $urandom_range(1, 3); end
      else begin pll_lock = 1'b0; seg = $urandom_range(5, 60); end
      for (int k = 0; k < seg; k++) begin
        tick();
        i++;
        total += 6;
        if (state !== 3'(m_state)) begin bad++; $display("FAIL rnd_state i=%0d: got %0d want %0d", i, state, m_state); end
        if (pll_reset !== (m_state == M_PLL_RST)) begin bad++; $display("FAIL rnd_pll_reset i=%0d: got %b", i, pll_reset); end
        if (sys_rst_n !== (m_state == M_RUN)) begin bad++; $display("FAIL rnd_sys_rst_n i=%0d: got %b", i, sys_rst_n); end
        if (ready !== (m_state == M_RUN)) begin bad++; $display("FAIL rnd_ready i=%0d: got %b", i, ready); end
        if (lock_loss_cnt !== 8'(m_loss)) begin bad++; $display("FAIL rnd_loss i=%0d: got %0d want %0d", i, lock_loss_cnt, m_loss); end
        if (timeout_cnt !== 8'(m_to)) begin bad++; $display("FAIL rnd_to i=%0d: got %0d want %0d", i, timeout_cnt, m_to); end
      end
    end
  endtask

  initial begin
    rst_n = 1'b0;
    pll_lock = 1'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_bringup();
    test_bounce();
    test_loss_in_run();
    test_async_reset();
    test_timeout();
    test_saturation();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #2000000;
    bad++;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
